// File: rtl/msg_comm_pkg.sv
// msg_comm_pkg: shared FSM encoding, defaults and saturating counter helper for the message TX arbiter
package msg_comm_pkg;
    typedef enum logic [2:0] {IDLE, ARB, LOAD, LEN, WAIT_ACK, DONE, ERR, GAP} state_t;
    localparam int MAX_LEN_DEF = 256;
    localparam int GAP_CYCLES_DEF = 4;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return &v ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int N = 4,
    parameter int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [N-1:0] rot;
    assign rot = N'({req, req} >> ptr);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) idx = IW'((int'(ptr) + i) % N);
        gnt = |req ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/msg_tx_arbiter.sv
// msg_tx_arbiter: round-robin sharing of one slave message TX path between REQ_NUM requesters
module msg_tx_arbiter
    import msg_comm_pkg::*;
#(
    parameter int REQ_NUM     = 4,
    parameter int MAX_LEN     = MAX_LEN_DEF,
    parameter int ACK_TIMEOUT = 65535,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_n_i,
    input  logic [REQ_NUM-1:0]    req_vld_i,
    input  logic [16*REQ_NUM-1:0] req_len_i,
    input  logic [8*REQ_NUM-1:0]  src_data_i,
    input  logic [REQ_NUM-1:0]    src_vld_i,
    output logic [REQ_NUM-1:0]    src_rdy_o,
    output logic [REQ_NUM-1:0]    done_o,
    output logic [REQ_NUM-1:0]    err_o,
    output logic                  slave_tx_en_o,
    output logic [7:0]            slave_tx_data_o,
    output logic                  slave_tx_byte_num_en_o,
    output logic [15:0]           slave_tx_byte_num_o,
    input  logic                  slave_tx_ack_i,
    output logic                  busy_o
);
    localparam int IW = REQ_NUM > 1 ? $clog2(REQ_NUM) : 1;
    state_t state;
    logic [IW-1:0] rr_ptr, grant, arb_idx, ptr_nxt;
    logic [REQ_NUM-1:0] arb_gnt, grant_oh;
    logic [15:0] len, byte_cnt, to_cnt, gap_cnt, arb_len, byte_nxt, to_nxt, gap_nxt;
    logic xfer;
    rr_arbiter #(.N(REQ_NUM)) u_rr (
        .req(req_vld_i),
        .ptr(rr_ptr),
        .gnt(arb_gnt),
        .idx(arb_idx)
    );
    assign arb_len   = req_len_i[arb_idx*16 +: 16];
    assign grant_oh  = REQ_NUM'(1) << grant;
    assign ptr_nxt   = (int'(grant) == REQ_NUM - 1) ? '0 : grant + 1'b1;
    assign src_rdy_o = (state == LOAD && byte_cnt < len) ? grant_oh : '0;
    assign xfer      = |(src_rdy_o & src_vld_i);
    assign busy_o    = state != IDLE;
    assign byte_nxt  = sat_inc(byte_cnt);
    assign to_nxt    = sat_inc(to_cnt);
    assign gap_nxt   = sat_inc(gap_cnt);
    // done/err are raised on the transition so each pulse coincides with the DONE/ERR state
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            state                  <= IDLE;
            rr_ptr                 <= '0;
            grant                  <= '0;
            len                    <= '0;
            byte_cnt               <= '0;
            to_cnt                 <= '0;
            gap_cnt                <= '0;
            done_o                 <= '0;
            err_o                  <= '0;
            slave_tx_en_o          <= 1'b0;
            slave_tx_data_o        <= '0;
            slave_tx_byte_num_en_o <= 1'b0;
            slave_tx_byte_num_o    <= '0;
        end else begin
            slave_tx_en_o          <= xfer;
            slave_tx_data_o        <= xfer ? src_data_i[grant*8 +: 8] : slave_tx_data_o;
            slave_tx_byte_num_en_o <= state == LEN;
            slave_tx_byte_num_o    <= state == LEN ? len : '0;
            done_o                 <= '0;
            err_o                  <= '0;
            case (state)
                IDLE: if (|req_vld_i) state <= ARB;
                ARB: begin
                    grant    <= arb_idx;
                    len      <= arb_len;
                    byte_cnt <= '0;
                    to_cnt   <= '0;
                    if (!(|arb_gnt)) state <= IDLE;
                    else if (arb_len == '0 || arb_len > 16'(MAX_LEN)) begin
                        state <= ERR;
                        err_o <= arb_gnt;
                    end else state <= LOAD;
                end
                LOAD: if (xfer) begin
                    byte_cnt <= byte_nxt;
                    if (byte_nxt >= len) state <= LEN;
                end
                LEN: state <= WAIT_ACK;
                WAIT_ACK: if (slave_tx_ack_i) begin
                    state  <= DONE;
                    done_o <= grant_oh;
                end else begin
                    to_cnt <= to_nxt;
                    if (to_nxt >= 16'(ACK_TIMEOUT)) begin
                        state <= ERR;
                        err_o <= grant_oh;
                    end
                end
                DONE, ERR: begin
                    state   <= GAP;
                    gap_cnt <= '0;
                    rr_ptr  <= ptr_nxt;
                end
                GAP: begin
                    gap_cnt <= gap_nxt;
                    if (gap_nxt >= 16'(GAP_CYCLES)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msg_tx_arbiter.sv
// tb_msg_tx_arbiter: table-driven scoreboard bench for msg_tx_arbiter
module tb_msg_tx_arbiter;
    localparam int N = 4, TO = 20, GAP = 4;
    logic clk_sys_i = 0, rst_n_i = 0, slave_tx_ack_i = 0;
    logic [N-1:0] req_vld_i = '0, src_vld_i = '0, src_rdy_o, done_o, err_o;
    logic [16*N-1:0] req_len_i = '0;
    logic [8*N-1:0] src_data_i = '0;
    logic slave_tx_en_o, slave_tx_byte_num_en_o, busy_o;
    logic [7:0] slave_tx_data_o;
    logic [15:0] slave_tx_byte_num_o;

    msg_tx_arbiter #(.REQ_NUM(N), .MAX_LEN(256), .ACK_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i), .req_vld_i(req_vld_i), .req_len_i(req_len_i),
        .src_data_i(src_data_i), .src_vld_i(src_vld_i), .src_rdy_o(src_rdy_o), .done_o(done_o),
        .err_o(err_o), .slave_tx_en_o(slave_tx_en_o), .slave_tx_data_o(slave_tx_data_o),
        .slave_tx_byte_num_en_o(slave_tx_byte_num_en_o), .slave_tx_byte_num_o(slave_tx_byte_num_o),
        .slave_tx_ack_i(slave_tx_ack_i), .busy_o(busy_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    typedef struct {
        int idx; int len; logic [7:0] base; int ack; bit tog; bit spur; bit exp_err; bit exp_to;
    } vec_t;
    vec_t vt[6];

    int n_chk = 0, n_err = 0, cyc = 0, n_evt = 0, t_len = 0, t_evt = 0, ack_dly = 0;
    bit spur = 0, phase = 0;
    int pos[N] = '{default: 0}, org[N] = '{default: 0}, cnt[N] = '{default: 0};
    logic [7:0] base[N] = '{default: 8'h00};
    bit tog[N] = '{default: 0}, hit[N] = '{default: 0};
    logic [7:0] q_byte[$], q_evt[$], mon_b, mon_e;
    int q_len[$], mon_l;

    always @(posedge clk_sys_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input bit ok, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] evt_code(input bit e, input int i);
        logic [3:0] oh = 4'b1 << i;
        return e ? {4'b0, oh} : {oh, 4'b0};
    endfunction

    // Source model: per-requester byte streams, optionally valid only every other cycle
    initial forever begin
        @(negedge clk_sys_i);
        for (int i = 0; i < N; i++) hit[i] = src_rdy_o[i] & src_vld_i[i];
        @(posedge clk_sys_i);
        #1;
        phase = ~phase;
        for (int i = 0; i < N; i++) begin
            if (hit[i]) pos[i]++;
            src_vld_i[i] = (pos[i] - org[i] < cnt[i]) && (!tog[i] || phase);
            src_data_i[i*8 +: 8] = base[i] + 8'(pos[i] - org[i]);
        end
    end

    // TX-path model: ack after ack_dly cycles, plus stray acks while bytes are still flowing
    initial forever begin
        @(negedge clk_sys_i);
        if (slave_tx_byte_num_en_o && ack_dly >= 0) begin
            if (ack_dly == 0) slave_tx_ack_i = 1;
            else begin
                repeat (ack_dly) @(posedge clk_sys_i);
                #1 slave_tx_ack_i = 1;
            end
            @(posedge clk_sys_i);
            #1 slave_tx_ack_i = 0;
        end else if (spur && slave_tx_en_o) begin
            slave_tx_ack_i = 1;
            @(posedge clk_sys_i);
            #1 slave_tx_ack_i = 0;
        end
    end

    // Scoreboard monitor
    initial forever begin
        @(negedge clk_sys_i);
        if (slave_tx_en_o) begin
            if (q_byte.size() == 0) chk("tx_byte_unexpected", 0, slave_tx_data_o, 0);
            else begin
                mon_b = q_byte.pop_front();
                chk("tx_byte", slave_tx_data_o == mon_b, slave_tx_data_o, mon_b);
            end
        end
        if (slave_tx_byte_num_en_o) begin
            t_len = cyc;
            if (q_len.size() == 0) chk("byte_num_unexpected", 0, slave_tx_byte_num_o, 0);
            else begin
                mon_l = q_len.pop_front();
                chk("byte_num", slave_tx_byte_num_o == 16'(mon_l), slave_tx_byte_num_o, mon_l);
            end
        end
        if ((done_o | err_o) != 0) begin
            t_evt = cyc;
            n_evt++;
            if (q_evt.size() == 0) chk("evt_unexpected", 0, {done_o, err_o}, 0);
            else begin
                mon_e = q_evt.pop_front();
                chk("done_err", {done_o, err_o} == mon_e, {done_o, err_o}, mon_e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic cfg(input int idx, input int len, input logic [7:0] b, input bit t);
        req_len_i[idx*16 +: 16] = 16'(len);
        base[idx] = b;
        org[idx] = pos[idx];
        cnt[idx] = len;
        tog[idx] = t;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"}, src_rdy_o == '0, src_rdy_o, 0);
        chk({tag, "_evt"}, {done_o, err_o} == '0, {done_o, err_o}, 0);
        chk({tag, "_tx"}, {slave_tx_en_o, slave_tx_data_o} == '0, {slave_tx_en_o, slave_tx_data_o}, 0);
        chk({tag, "_num"}, {slave_tx_byte_num_en_o, slave_tx_byte_num_o} == '0,
            {slave_tx_byte_num_en_o, slave_tx_byte_num_o}, 0);
        chk({tag, "_busy"}, !busy_o, busy_o, 0);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 50 && busy_o; c++) @(negedge clk_sys_i);
        chk("busy_low", !busy_o, busy_o, 0);
    endtask

    task automatic run_vec(input vec_t v);
        bit len_err = v.exp_err && !v.exp_to;
        int n0 = n_evt;
        cfg(v.idx, v.len, v.base, v.tog);
        if (len_err) cnt[v.idx] = v.len == 0 ? 4 : v.len;
        else begin
            for (int k = 0; k < v.len; k++) q_byte.push_back(v.base + 8'(k));
            q_len.push_back(v.len);
        end
        q_evt.push_back(evt_code(v.exp_err, v.idx));
        ack_dly = v.ack;
        spur = v.spur;
        req_vld_i[v.idx] = 1;
        for (int c = 0; c < 2000 && n_evt == n0; c++) @(negedge clk_sys_i);
        chk("evt_seen", n_evt != n0, n_evt - n0, 1);
        req_vld_i[v.idx] = 0;
        cnt[v.idx] = 0;
        spur = 0;
        if (v.exp_to) chk("timeout_cycles", t_evt - t_len == TO, t_evt - t_len, TO);
        else if (!v.exp_err) chk("ack_latency", t_evt - t_len == v.ack + 1, t_evt - t_len, v.ack + 1);
        wait_idle();
        chk("queues_drained", q_byte.size() + q_len.size() + q_evt.size() == 0,
            q_byte.size() + q_len.size() + q_evt.size(), 0);
    endtask

    task automatic run_multi(input logic [3:0] mask);
        int t_last = -1;
        bit prev = 0;
        ack_dly = 0;
        spur = 0;
        req_vld_i = mask;
        for (int c = 0; c < 500 && req_vld_i != 0; c++) begin
            @(negedge clk_sys_i);
            if (|src_rdy_o && !prev && t_last >= 0)
                chk("gap_idle", cyc - t_last - 1 >= GAP, cyc - t_last - 1, GAP);
            prev = |src_rdy_o;
            if ((done_o | err_o) != 0) begin
                t_last = cyc;
                req_vld_i = req_vld_i & ~(done_o | err_o);
            end
        end
        chk("multi_complete", req_vld_i == 0, req_vld_i, 0);
        wait_idle();
    endtask

    initial begin
        vt[0] = '{0, 3,   8'hA1, 10, 0, 1, 0, 0};
        vt[1] = '{2, 0,   8'h00, 0,  0, 0, 1, 0};
        vt[2] = '{2, 257, 8'h00, 0,  0, 0, 1, 0};
        vt[3] = '{1, 2,   8'h30, -1, 0, 0, 1, 1};
        vt[4] = '{3, 256, 8'h00, 3,  0, 0, 0, 0};
        vt[5] = '{1, 8,   8'h80, 2,  1, 1, 0, 0};
        repeat (3) @(posedge clk_sys_i);
        @(negedge clk_sys_i);
        chk_idle("reset");
        rst_n_i = 1;
        @(negedge clk_sys_i);
        for (int i = 0; i < N; i++) begin
            cfg(i, 1, 8'h11 * 8'(i + 1), 0);
            q_byte.push_back(8'h11 * 8'(i + 1));
            q_len.push_back(1);
            q_evt.push_back(evt_code(0, i));
        end
        run_multi(4'hF);
        for (int i = 0; i < 6; i++) run_vec(vt[i]);
        cfg(2, 5, 8'h50, 0);
        q_byte.push_back(8'h50);
        q_byte.push_back(8'h51);
        req_vld_i[2] = 1;
        for (int c = 0; c < 100 && pos[2] - org[2] < 2; c++) @(negedge clk_sys_i);
        chk("partial_load", pos[2] - org[2] == 2, pos[2] - org[2], 2);
        rst_n_i = 0;
        req_vld_i = '0;
        cnt[2] = 0;
        @(negedge clk_sys_i);
        chk_idle("abort");
        rst_n_i = 1;
        repeat (6) @(negedge clk_sys_i);
        cfg(1, 1, 8'h61, 0);
        cfg(3, 1, 8'h63, 0);
        q_byte.push_back(8'h61);
        q_byte.push_back(8'h63);
        q_len.push_back(1);
        q_len.push_back(1);
        q_evt.push_back(evt_code(0, 1));
        q_evt.push_back(evt_code(0, 3));
        run_multi(4'b1010);
        chk("scoreboard_empty", q_byte.size() + q_len.size() + q_evt.size() == 0,
            q_byte.size() + q_len.size() + q_evt.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
